// File: rtl/dmem_port_arbiter.sv
// Shares one synchronous-read data memory between the CPU (priority), the VGA fetch
// port and the loader port. Starved secondaries force a one-cycle CPU stall.
module dmem_port_arbiter #(
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_en,
    input  logic        cpu_we,
    input  logic [7:0]  cpu_addr,
    input  logic [15:0] cpu_wdata,
    output logic [15:0] cpu_rdata,
    output logic        cpu_stall,
    input  logic        vid_req,
    input  logic [7:0]  vid_addr,
    output logic        vid_ack,
    output logic [15:0] vid_rdata,
    input  logic        ld_req,
    input  logic        ld_we,
    input  logic [7:0]  ld_addr,
    input  logic [15:0] ld_wdata,
    output logic        ld_ack,
    output logic [15:0] ld_rdata,
    output logic        m_we,
    output logic [7:0]  m_addr,
    output logic [15:0] m_wdata,
    input  logic [15:0] m_rdata
);

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_VID  = 2'd2,
        OWN_LD   = 2'd3
    } owner_t;

    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    state_t      state_r;
    state_t      state_nxt_s;
    owner_t      owner_s;
    logic [7:0]  vid_cnt_r;
    logic [7:0]  vid_cnt_nxt_s;
    logic [7:0]  ld_cnt_r;
    logic [7:0]  ld_cnt_nxt_s;
    logic        rr_r;          // 1'b0: vid favoured on a tie, 1'b1: ld favoured
    logic        rr_nxt_s;
    logic        vid_ack_r;
    logic        ld_ack_r;
    logic        vid_elig_s;
    logic        ld_elig_s;
    logic        vid_grant_s;
    logic        ld_grant_s;

    // Counter stops at LIMIT so a port waiting in STALL behind the other holds its claim.
    function automatic logic [7:0] wait_next(input logic [7:0] cnt, input logic req,
                                             input logic elig, input logic grant);
        logic [7:0] nxt;
        if (grant || !req) begin
            nxt = 8'd0;
        end else if (elig && (cnt < LIMIT)) begin
            nxt = cnt + 8'd1;
        end else begin
            nxt = cnt;
        end
        return nxt;
    endfunction

    assign vid_elig_s  = vid_req && !vid_ack_r;
    assign ld_elig_s   = ld_req && !ld_ack_r;
    assign vid_grant_s = (owner_s == OWN_VID);
    assign ld_grant_s  = (owner_s == OWN_LD);

    assign cpu_stall = (state_r == ST_STALL);
    assign vid_ack   = vid_ack_r;
    assign ld_ack    = ld_ack_r;
    assign cpu_rdata = m_rdata;
    assign vid_rdata = m_rdata;
    assign ld_rdata  = m_rdata;

    // Select the memory owner for this cycle.
    always_comb begin
        owner_s = OWN_NONE;
        case (state_r)
            ST_STALL: begin
                if (vid_req && (vid_cnt_r == LIMIT)) begin
                    owner_s = OWN_VID;
                end else if (ld_req && (ld_cnt_r == LIMIT)) begin
                    owner_s = OWN_LD;
                end else begin
                    owner_s = OWN_NONE;
                end
            end
            ST_RUN: begin
                if (cpu_en) begin
                    owner_s = OWN_CPU;
                end else if (vid_elig_s && ld_elig_s) begin
                    owner_s = rr_r ? OWN_LD : OWN_VID;
                end else if (vid_elig_s) begin
                    owner_s = OWN_VID;
                end else if (ld_elig_s) begin
                    owner_s = OWN_LD;
                end else begin
                    owner_s = OWN_NONE;
                end
            end
            default: begin
                owner_s = OWN_NONE;
            end
        endcase
    end

    // Wait counters, round-robin pointer and the stall decision.
    always_comb begin
        vid_cnt_nxt_s = wait_next(vid_cnt_r, vid_req, vid_elig_s, vid_grant_s);
        ld_cnt_nxt_s  = wait_next(ld_cnt_r, ld_req, ld_elig_s, ld_grant_s);
        if (vid_grant_s) begin
            rr_nxt_s = 1'b1;
        end else if (ld_grant_s) begin
            rr_nxt_s = 1'b0;
        end else begin
            rr_nxt_s = rr_r;
        end
        if ((vid_cnt_nxt_s == LIMIT) || (ld_cnt_nxt_s == LIMIT)) begin
            state_nxt_s = ST_STALL;
        end else begin
            state_nxt_s = ST_RUN;
        end
    end

    // Memory command mux; writes are suppressed while reset is held.
    always_comb begin
        m_we    = 1'b0;
        m_addr  = 8'h00;
        m_wdata = 16'h0000;
        case (owner_s)
            OWN_CPU: begin
                m_we    = cpu_we;
                m_addr  = cpu_addr;
                m_wdata = cpu_wdata;
            end
            OWN_VID: begin
                m_addr  = vid_addr;
            end
            OWN_LD: begin
                m_we    = ld_we;
                m_addr  = ld_addr;
                m_wdata = ld_wdata;
            end
            default: begin
                m_we    = 1'b0;
            end
        endcase
        if (reset) begin
            m_we = 1'b0;
        end else begin
            m_we = m_we;
        end
    end

    // State, counters, pointer and ack registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= ST_RUN;
            vid_cnt_r <= 8'd0;
            ld_cnt_r  <= 8'd0;
            rr_r      <= 1'b0;
            vid_ack_r <= 1'b0;
            ld_ack_r  <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            vid_cnt_r <= vid_cnt_nxt_s;
            ld_cnt_r  <= ld_cnt_nxt_s;
            rr_r      <= rr_nxt_s;
            vid_ack_r <= vid_grant_s;
            ld_ack_r  <= ld_grant_s;
        end
    end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Scoreboard bench for dmem_port_arbiter with a behavioural synchronous-read memory.
module tb_dmem_port_arbiter;

    logic        clk;
    logic        reset;
    logic        cpu_en, cpu_we;
    logic [7:0]  cpu_addr;
    logic [15:0] cpu_wdata, cpu_rdata;
    logic        cpu_stall;
    logic        vid_req;
    logic [7:0]  vid_addr;
    logic        vid_ack;
    logic [15:0] vid_rdata;
    logic        ld_req, ld_we;
    logic [7:0]  ld_addr;
    logic [15:0] ld_wdata;
    logic        ld_ack;
    logic [15:0] ld_rdata;
    logic        m_we;
    logic [7:0]  m_addr;
    logic [15:0] m_wdata, m_rdata;

    logic [15:0] mem [256];
    logic [15:0] vid_q[$];
    logic [15:0] ld_q[$];
    logic [15:0] cpu_q[$];
    int          checks = 0;
    int          errors = 0;

    dmem_port_arbiter #(.STARVE_LIMIT(8)) dut (
        .clk(clk), .reset(reset),
        .cpu_en(cpu_en), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_rdata(vid_rdata),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_ack(ld_ack), .ld_rdata(ld_rdata),
        .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read memory, read-before-write.
    always @(posedge clk) begin
        if (m_we) mem[m_addr] <= m_wdata;
        m_rdata <= mem[m_addr];
    end

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        cpu_en = 1'b0; cpu_we = 1'b0; cpu_addr = 8'h00; cpu_wdata = 16'h0000;
        vid_req = 1'b0; vid_addr = 8'h00;
        ld_req = 1'b0; ld_we = 1'b0; ld_addr = 8'h00; ld_wdata = 16'h0000;
    endtask

    task automatic do_reset();
        next_cycle();
        reset = 1'b1;
        clear_inputs();
        next_cycle();
        reset = 1'b0;
    endtask

    // Monitor: pops expected data whenever the DUT presents a response.
    initial begin
        logic cpu_rd_pend;
        cpu_rd_pend = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                cpu_rd_pend = 1'b0;
            end else begin
                if (cpu_rd_pend) begin
                    if (cpu_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL cpu_rdata_unexpected: got %h expected none", cpu_rdata);
                    end else begin
                        check("cpu_rdata", 32'(cpu_rdata), 32'(cpu_q.pop_front()));
                    end
                end
                cpu_rd_pend = cpu_en && !cpu_we && !cpu_stall;
                if (vid_ack) begin
                    if (vid_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL vid_ack_unexpected: got ack expected none at %0t", $time);
                    end else begin
                        check("vid_rdata", 32'(vid_rdata), 32'(vid_q.pop_front()));
                    end
                end
                if (ld_ack) begin
                    if (ld_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL ld_ack_unexpected: got ack expected none at %0t", $time);
                    end else begin
                        check("ld_rdata", 32'(ld_rdata), 32'(ld_q.pop_front()));
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h1000 + 16'(i);
        clear_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_stall", 32'(cpu_stall), 32'd0);
        check("rst_vid_ack", 32'(vid_ack), 32'd0);
        check("rst_ld_ack", 32'(ld_ack), 32'd0);
        check("rst_m_we", 32'(m_we), 32'd0);

        // CPU write then read back
        next_cycle();
        cpu_en = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h10; cpu_wdata = 16'hBEEF;
        @(negedge clk);
        check("cpu_wr_m_we", 32'(m_we), 32'd1);
        check("cpu_wr_m_addr", 32'(m_addr), 32'h10);
        check("cpu_wr_m_wdata", 32'(m_wdata), 32'hBEEF);
        check("cpu_wr_stall", 32'(cpu_stall), 32'd0);
        next_cycle();
        cpu_we = 1'b0; cpu_q.push_back(16'hBEEF);
        @(negedge clk);
        check("cpu_rd_m_we", 32'(m_we), 32'd0);
        check("cpu_rd_stall", 32'(cpu_stall), 32'd0);
        next_cycle();
        cpu_en = 1'b0;
        @(negedge clk);
        check("cpu_idle_stall", 32'(cpu_stall), 32'd0);

        // vid alone
        next_cycle();
        vid_req = 1'b1; vid_addr = 8'h10; vid_q.push_back(16'hBEEF);
        @(negedge clk);
        check("vid_m_addr", 32'(m_addr), 32'h10);
        check("vid_m_we", 32'(m_we), 32'd0);
        check("vid_ack_early", 32'(vid_ack), 32'd0);
        next_cycle();
        vid_req = 1'b0;
        @(negedge clk);
        check("vid_ack_pulse", 32'(vid_ack), 32'd1);
        next_cycle();
        @(negedge clk);
        check("vid_ack_clear", 32'(vid_ack), 32'd0);

        // vid and ld held together: alternate grants
        do_reset();
        for (int k = 0; k < 8; k++) begin
            next_cycle();
            vid_req = (k < 6); ld_req = (k < 6); vid_addr = 8'h20; ld_addr = 8'h30; ld_we = 1'b0;
            if (k < 6) begin
                if (k % 2 == 0) vid_q.push_back(16'h1020);
                else ld_q.push_back(16'h1030);
            end
            @(negedge clk);
            if (k < 6) check($sformatf("rr_m_addr_%0d", k), 32'(m_addr), (k % 2 == 0) ? 32'h20 : 32'h30);
            check($sformatf("rr_vid_ack_%0d", k), 32'(vid_ack), 32'(k >= 1 && k <= 5 && (k % 2 == 1)));
            check($sformatf("rr_ld_ack_%0d", k), 32'(ld_ack), 32'(k >= 2 && k <= 6 && (k % 2 == 0)));
        end

        // loader write, then display reads it back
        next_cycle();
        ld_req = 1'b1; ld_we = 1'b1; ld_addr = 8'h70; ld_wdata = 16'h1234; ld_q.push_back(16'h1070);
        @(negedge clk);
        check("ld_wr_m_we", 32'(m_we), 32'd1);
        check("ld_wr_m_addr", 32'(m_addr), 32'h70);
        check("ld_wr_m_wdata", 32'(m_wdata), 32'h1234);
        next_cycle();
        ld_req = 1'b0; ld_we = 1'b0; vid_req = 1'b1; vid_addr = 8'h70; vid_q.push_back(16'h1234);
        @(negedge clk);
        check("ld_wr_ack", 32'(ld_ack), 32'd1);
        check("vid_rb_m_addr", 32'(m_addr), 32'h70);
        next_cycle();
        vid_req = 1'b0;
        @(negedge clk);
        check("vid_rb_ack", 32'(vid_ack), 32'd1);

        // CPU busy, vid starves -> single stall at cycle 8
        do_reset();
        for (int k = 0; k < 11; k++) begin
            next_cycle();
            cpu_en = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h10; vid_req = (k < 9); vid_addr = 8'h40;
            if (k != 8) cpu_q.push_back(16'hBEEF);
            else vid_q.push_back(16'h1040);
            @(negedge clk);
            check($sformatf("st1_stall_%0d", k), 32'(cpu_stall), 32'(k == 8));
            check($sformatf("st1_vid_ack_%0d", k), 32'(vid_ack), 32'(k == 9));
            if (k == 8) check("st1_m_addr", 32'(m_addr), 32'h40);
        end
        next_cycle();
        cpu_en = 1'b0; vid_req = 1'b0;
        @(negedge clk);
        check("st1_end_stall", 32'(cpu_stall), 32'd0);

        // both starve -> two stall cycles, vid then ld
        do_reset();
        for (int k = 0; k < 12; k++) begin
            next_cycle();
            cpu_en = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h10;
            vid_req = (k < 9); vid_addr = 8'h40; ld_req = (k < 10); ld_addr = 8'h50; ld_we = 1'b0;
            if (k == 8) vid_q.push_back(16'h1040);
            else if (k == 9) ld_q.push_back(16'h1050);
            else cpu_q.push_back(16'hBEEF);
            @(negedge clk);
            check($sformatf("st2_stall_%0d", k), 32'(cpu_stall), 32'(k == 8 || k == 9));
            check($sformatf("st2_vid_ack_%0d", k), 32'(vid_ack), 32'(k == 9));
            check($sformatf("st2_ld_ack_%0d", k), 32'(ld_ack), 32'(k == 10));
            if (k == 8) check("st2_m_addr_vid", 32'(m_addr), 32'h40);
            if (k == 9) check("st2_m_addr_ld", 32'(m_addr), 32'h50);
        end
        next_cycle();
        cpu_en = 1'b0; vid_req = 1'b0; ld_req = 1'b0;
        @(negedge clk);
        check("st2_end_stall", 32'(cpu_stall), 32'd0);

        // starved port drops req in the stall cycle: no grant, no ack
        do_reset();
        for (int k = 0; k < 10; k++) begin
            next_cycle();
            cpu_en = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h60; cpu_wdata = 16'h5555;
            vid_req = (k < 8); vid_addr = 8'h40;
            @(negedge clk);
            check($sformatf("drop_stall_%0d", k), 32'(cpu_stall), 32'(k == 8));
            check($sformatf("drop_vid_ack_%0d", k), 32'(vid_ack), 32'd0);
            if (k == 8) check("drop_m_we", 32'(m_we), 32'd0);
        end

        // reset mid-stall aborts the pending ack
        do_reset();
        for (int k = 0; k < 9; k++) begin
            next_cycle();
            cpu_en = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h60; cpu_wdata = 16'h5555;
            vid_req = 1'b1; vid_addr = 8'h40;
            @(negedge clk);
            check($sformatf("rs_stall_%0d", k), 32'(cpu_stall), 32'(k == 8));
        end
        #1 reset = 1'b1;
        #1;
        check("rs_async_stall", 32'(cpu_stall), 32'd0);
        check("rs_async_vid_ack", 32'(vid_ack), 32'd0);
        check("rs_async_ld_ack", 32'(ld_ack), 32'd0);
        check("rs_async_m_we", 32'(m_we), 32'd0);
        check("rs_async_vid_cnt", 32'(dut.vid_cnt_r), 32'd0);
        check("rs_async_ld_cnt", 32'(dut.ld_cnt_r), 32'd0);
        @(negedge clk);
        check("rs_held_vid_ack", 32'(vid_ack), 32'd0);
        check("rs_held_m_we", 32'(m_we), 32'd0);
        check("rs_held_stall", 32'(cpu_stall), 32'd0);
        next_cycle();
        reset = 1'b0;
        clear_inputs();
        @(negedge clk);
        check("rs_after_vid_ack", 32'(vid_ack), 32'd0);
        check("rs_after_stall", 32'(cpu_stall), 32'd0);

        next_cycle();
        next_cycle();
        @(negedge clk);
        check("vid_q_empty", 32'(vid_q.size()), 32'd0);
        check("ld_q_empty", 32'(ld_q.size()), 32'd0);
        check("cpu_q_empty", 32'(cpu_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_port_arbiter.md
# dmem_port_arbiter

Three-way arbiter that shares the single-port data memory (8-bit address, 16-bit data, synchronous read) between the pipelined CPU's data port, the VGA display fetch port and the program/debug loader port. The CPU has priority, and the two secondary ports are served round-robin in cycles the CPU leaves idle. A per-port starvation counter and a small FSM stall the CPU for one cycle whenever a secondary port has waited STARVE_LIMIT cycles. It sits between PCPU's d_addr/d_dataout/d_we/d_datain path and Data_Memory.

## Interface
- STARVE_LIMIT, 8, consecutive un-granted request cycles before a forced grant (legal range 2..255)
- clk  in  1  system clock, also the memory clock
- reset  in  1  asynchronous, active-high
- cpu_en  in  1  CPU memory access this cycle
- cpu_we  in  1  CPU write (with cpu_en)
- cpu_addr  in  8  CPU address
- cpu_wdata  in  16  CPU write data
- cpu_rdata  out  16  m_rdata passthrough, valid the cycle after a CPU read grant
- cpu_stall  out  1  CPU must hold its access; access not performed this cycle
- vid_req  in  1  display read request (read-only port)
- vid_addr  in  8  display address
- vid_ack  out  1  one-cycle pulse, vid_rdata valid
- vid_rdata  out  16  display read data
- ld_req, ld_we  in  1,1  loader request / write
- ld_addr  in  8; ld_wdata  in  16  loader address / data
- ld_ack  out  1; ld_rdata  out  16  loader completion pulse / read data
- m_we  out  1; m_addr  out  8; m_wdata  out  16  memory command (combinational from owner)
- m_rdata  in  16  memory read data, valid one cycle after address

## Operation
- FSM states: RUN, STALL. cpu_stall = (state==STALL), Moore output.
- Owner per cycle (combinational):
  - STALL: the starved port, vid if both are starved.
  - RUN with cpu_en: CPU.
  - RUN otherwise: the eligible secondary; if both are eligible, the one not served last (rr pointer).
  - No request: no owner, m_we=0.
- Eligible secondary: req=1 and not granted in the previous cycle, i.e. no ack pending. Each secondary therefore gets at most one access per 2 cycles.
- Granted secondary X in cycle N: X_ack=1 in N+1, X_rdata=m_rdata registered-through. ld writes still ack.
- Requesters hold req/addr/data until ack. They may keep req high at ack with a new address, and become eligible again at N+2.
- Wait counters (8-bit, saturating): cleared on grant or req=0; incremented when req=1, eligible and not granted.
- RUN->STALL at the edge where any counter's next value equals STARVE_LIMIT.
- STALL grants the starved port, clears its counter, then:
  - stays in STALL if the other counter is also at LIMIT;
  - otherwise returns to RUN.
- rr pointer toggles to "other" on every secondary grant, including grants made in STALL.
- Address/data width rules: straight mux, no wrap or translation.

## Timing
- Reset (async) values: state=RUN, counters=0, rr pointer favours vid, vid_ack=ld_ack=0, cpu_stall=0. m_we forced 0 while reset is high.
- CPU latency: write lands at the end of the grant cycle; read data appears on cpu_rdata in the next cycle.
- Secondary latency: grant cycle + 1 to ack. Minimum request-to-ack is 1 cycle when the CPU is idle.
- Worst-case secondary wait is STARVE_LIMIT cycles, then grant. With both starved, the CPU is stalled for 2 consecutive cycles.
- Boundary cases:
  - cpu_en arriving in a STALL cycle is ignored, and the CPU retries.
  - A starved port that drops req is cleared; STALL is still taken only if entered, and then grants nothing, with no ack.
  - Reset asserted mid-STALL aborts immediately, and the pending ack is lost.

## Test plan
- CPU only: write 0xBEEF@0x10, then read 0x10 -> cpu_rdata=0xBEEF one cycle after the read, cpu_stall never 1.
- vid alone, cpu idle, vid_req@addr 0x10 -> m_addr=0x10 same cycle, vid_ack next cycle with vid_rdata=0xBEEF.
- vid_req and ld_req held continuously, cpu idle -> grants alternate vid, ld, vid, ...; vid_ack/ld_ack each pulse every 2 cycles.
- cpu_en held high, vid_req raised at cycle 0, LIMIT=8 -> cpu_stall=1 in cycle 8 only, vid granted in cycle 8, vid_ack in cycle 9.
- cpu_en high, vid_req and ld_req both raised at cycle 0 -> cpu_stall high in cycles 8-9, vid granted in 8, ld granted in 9.
- Reset pulsed during a STALL cycle -> cpu_stall=0, both acks 0, counters 0 immediately, m_we=0 while reset is held.
